// File: rtl/gascon_perm_core.sv
// Iterative Gascon permutation: applies a run-time round count (clamped to MAX_ROUNDS) to the
// CWIDTH-bit state, UNROLL rounds per clock, with valid/ready handshakes and output backpressure.
module gascon_perm_core #(
  parameter int unsigned CWIDTH     = 320,
  parameter int unsigned MAX_ROUNDS = 12,
  parameter int unsigned UNROLL     = 1,
  parameter int unsigned RCNT_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CWIDTH-1:0] c,
  input  logic [RCNT_W-1:0] num_rounds,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CWIDTH-1:0] cout,
  output logic              busy
);

  localparam int unsigned NW    = CWIDTH / 64;
  localparam int unsigned MID   = (NW - 1) / 2;
  localparam int unsigned CNT_W = $clog2(MAX_ROUNDS + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StDone, StOut} state_e;

  state_e              r_st;
  logic [CWIDTH-1:0]   r_s;
  logic [CNT_W-1:0]    r_n;
  logic [CNT_W-1:0]    r_b;
  logic [CNT_W-1:0]    r_i;
  logic                r_out_valid;
  logic [CWIDTH-1:0]   r_cout;
  logic                r_busy;

  logic [CWIDTH-1:0]   w_next;
  logic [CNT_W-1:0]    w_step;
  logic                w_last;
  logic [CNT_W-1:0]    w_n_clamp;

  function automatic logic [63:0] f_rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Per-word rotation pair of the linear layer; words beyond the ninth reuse the table.
  function automatic logic [63:0] f_lin(input logic [63:0] x, input int unsigned w);
    case (w % 9)
      0:       return x ^ f_rotr(x, 19) ^ f_rotr(x, 28);
      1:       return x ^ f_rotr(x, 61) ^ f_rotr(x, 38);
      2:       return x ^ f_rotr(x, 1)  ^ f_rotr(x, 6);
      3:       return x ^ f_rotr(x, 10) ^ f_rotr(x, 17);
      4:       return x ^ f_rotr(x, 7)  ^ f_rotr(x, 40);
      5:       return x ^ f_rotr(x, 31) ^ f_rotr(x, 26);
      6:       return x ^ f_rotr(x, 53) ^ f_rotr(x, 58);
      7:       return x ^ f_rotr(x, 9)  ^ f_rotr(x, 46);
      default: return x ^ f_rotr(x, 43) ^ f_rotr(x, 50);
    endcase
  endfunction

  // One round: constant add, bit-sliced S-box (chi with pre/post xor chains), linear layer.
  function automatic logic [CWIDTH-1:0] f_round(input logic [CWIDTH-1:0] s, input logic [3:0] k);
    logic [63:0]       x [NW];
    logic [63:0]       t [NW];
    logic [CWIDTH-1:0] res;
    for (int w = 0; w < NW; w++) x[w] = s[64*w +: 64];
    x[MID] = x[MID] ^ {56'b0, 4'hF - k, k};
    for (int j = 0; j < NW; j += 2) x[j] = x[j] ^ x[(j + NW - 1) % NW];
    for (int w = 0; w < NW; w++) t[w] = ~x[w] & x[(w + 1) % NW];
    for (int w = 0; w < NW; w++) x[w] = x[w] ^ t[(w + 1) % NW];
    for (int j = 0; j < NW; j += 2) x[(j + 1) % NW] = x[(j + 1) % NW] ^ x[j];
    x[MID] = ~x[MID];
    for (int w = 0; w < NW; w++) res[64*w +: 64] = f_lin(x[w], w);
    return res;
  endfunction

  always_comb begin
    w_n_clamp = (int'(num_rounds) > int'(MAX_ROUNDS)) ? CNT_W'(MAX_ROUNDS) : CNT_W'(num_rounds);
  end

  // Unrolled chain; stages past the last requested round pass the state through untouched.
  always_comb begin
    w_next = r_s;
    w_step = '0;
    for (int u = 0; u < int'(UNROLL); u++) begin
      if (int'(r_i) + u < int'(r_n)) begin
        w_next = f_round(w_next, 4'(int'(r_b) + int'(r_i) + u));
        w_step = w_step + CNT_W'(1);
      end
    end
    w_last = (int'(r_i) + int'(w_step) == int'(r_n));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st        <= StIdle;
      r_s         <= '0;
      r_n         <= '0;
      r_b         <= '0;
      r_i         <= '0;
      r_out_valid <= 1'b0;
      r_cout      <= '0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_st)
        StIdle: begin
          if (in_valid) begin
            r_s    <= c;
            r_n    <= w_n_clamp;
            r_b    <= CNT_W'(MAX_ROUNDS) - w_n_clamp;
            r_i    <= '0;
            r_busy <= 1'b1;
            r_st   <= StLoad;
          end
        end
        StLoad: begin
          if (r_n == '0) begin
            r_busy <= 1'b0;
            r_st   <= StDone;
          end else begin
            r_st <= StRun;
          end
        end
        StRun: begin
          r_s <= w_next;
          r_i <= r_i + w_step;
          if (w_last) begin
            r_busy <= 1'b0;
            r_st   <= StDone;
          end
        end
        StDone: begin
          r_out_valid <= 1'b1;
          r_cout      <= r_s;
          r_st        <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_cout      <= '0;
            r_st        <= StIdle;
          end
        end
        default: r_st <= StIdle;
      endcase
    end
  end

  assign in_ready  = (r_st == StIdle) && !reset;
  assign out_valid = r_out_valid;
  assign cout      = r_cout;
  assign busy      = r_busy;

endmodule

// File: tb/tb_gascon_perm_core.sv
// Directed and random checks of gascon_perm_core against a table-driven Gascon-320 model,
// using one default instance (UNROLL=1) and one with UNROLL=3.
module tb_gascon_perm_core;

  localparam int unsigned CW = 320;
  localparam logic [CW-1:0] PAT =
    320'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [CW-1:0] c, cout;
  logic [3:0]    num_rounds;
  logic          in_valid3, in_ready3, out_valid3, out_ready3, busy3;
  logic [CW-1:0] c3, cout3;
  logic [3:0]    num_rounds3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gascon_perm_core dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .c(c),
    .num_rounds(num_rounds), .out_valid(out_valid), .out_ready(out_ready), .cout(cout),
    .busy(busy));

  gascon_perm_core #(.UNROLL(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3), .c(c3),
    .num_rounds(num_rounds3), .out_valid(out_valid3), .out_ready(out_ready3), .cout(cout3),
    .busy(busy3));

  function automatic logic [CW-1:0] model(input logic [CW-1:0] s, input int nr);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  o;
    logic [3:0]  k;
    logic [CW-1:0] res;
    int n = (nr > 12) ? 12 : nr;
    for (int w = 0; w < 5; w++) x[w] = s[64*w +: 64];
    for (int r = 12 - n; r < 12; r++) begin
      k = 4'(r);
      x[2] = x[2] ^ {56'h0, ~k, k};
      for (int b = 0; b < 64; b++) begin
        o = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
        {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]} = o;
      end
      y[0] = x[0] ^ {x[0][18:0], x[0][63:19]} ^ {x[0][27:0], x[0][63:28]};
      y[1] = x[1] ^ {x[1][60:0], x[1][63:61]} ^ {x[1][37:0], x[1][63:38]};
      y[2] = x[2] ^ {x[2][0], x[2][63:1]}     ^ {x[2][5:0], x[2][63:6]};
      y[3] = x[3] ^ {x[3][9:0], x[3][63:10]}  ^ {x[3][16:0], x[3][63:17]};
      y[4] = x[4] ^ {x[4][6:0], x[4][63:7]}   ^ {x[4][39:0], x[4][63:40]};
      x = y;
    end
    for (int w = 0; w < 5; w++) res[64*w +: 64] = x[w];
    return res;
  endfunction

  // Accepts one vector and returns the result plus edges from accept to out_valid (100=timeout).
  task automatic run_op(input bit u3, input logic [CW-1:0] cv, input logic [3:0] nr,
                        output logic [CW-1:0] res, output int lat);
    @(negedge clk);
    if (u3) begin in_valid3 = 1'b1; c3 = cv; num_rounds3 = nr; end
    else    begin in_valid  = 1'b1; c  = cv; num_rounds  = nr; end
    @(negedge clk);
    if (u3) begin in_valid3 = 1'b0; c3 = ~cv; num_rounds3 = ~nr; end
    else    begin in_valid  = 1'b0; c  = ~cv; num_rounds  = ~nr; end
    lat = 0;
    while (lat < 100 && !(u3 ? out_valid3 : out_valid)) begin
      @(negedge clk);
      lat++;
    end
    res = u3 ? cout3 : cout;
  endtask

  task automatic consume(input bit u3);
    if (u3) out_ready3 = 1'b1; else out_ready = 1'b1;
    @(negedge clk);
    out_ready3 = 1'b0;
    out_ready  = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks += 4;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    if (cout !== '0) begin errors++; $display("FAIL rst_cout got %h want 0", cout); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
    if (in_ready3 !== 1'b1) begin errors++; $display("FAIL idle_in_ready3 got %b want 1", in_ready3); end
  endtask

  task automatic test_full_rounds;
    logic [CW-1:0] res;
    int lat;
    run_op(1'b0, '0, 4'd12, res, lat);
    checks += 3;
    if (lat !== 14) begin errors++; $display("FAIL full_latency got %0d want 14", lat); end
    if (res !== model('0, 12)) begin errors++; $display("FAIL full_cout got %h want %h", res, model('0, 12)); end
    if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_out got %b want 0", busy); end
    consume(1'b0);
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL full_ov_after got %b want 0", out_valid); end
    if (cout !== '0) begin errors++; $display("FAIL full_cout_after got %h want 0", cout); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_passthrough_clamp;
    logic [CW-1:0] res;
    int lat;
    run_op(1'b0, PAT, 4'd0, res, lat);
    checks += 2;
    if (lat !== 2) begin errors++; $display("FAIL pass_latency got %0d want 2", lat); end
    if (res !== PAT) begin errors++; $display("FAIL pass_cout got %h want %h", res, PAT); end
    consume(1'b0);
    run_op(1'b0, PAT, 4'd15, res, lat);
    checks += 2;
    if (lat !== 14) begin errors++; $display("FAIL clamp_latency got %0d want 14", lat); end
    if (res !== model(PAT, 12)) begin errors++; $display("FAIL clamp_cout got %h want %h", res, model(PAT, 12)); end
    consume(1'b0);
  endtask

  task automatic test_unroll;
    logic [CW-1:0] res;
    int lat;
    run_op(1'b1, PAT, 4'd7, res, lat);
    checks += 2;
    if (lat !== 5) begin errors++; $display("FAIL u3_n7_latency got %0d want 5", lat); end
    if (res !== model(PAT, 7)) begin errors++; $display("FAIL u3_n7_cout got %h want %h", res, model(PAT, 7)); end
    consume(1'b1);
    run_op(1'b1, ~PAT, 4'd12, res, lat);
    checks += 2;
    if (lat !== 6) begin errors++; $display("FAIL u3_n12_latency got %0d want 6", lat); end
    if (res !== model(~PAT, 12)) begin errors++; $display("FAIL u3_n12_cout got %h want %h", res, model(~PAT, 12)); end
    consume(1'b1);
  endtask

  task automatic test_backpressure;
    logic [CW-1:0] res;
    logic [CW-1:0] exp_r;
    int lat;
    exp_r = model(PAT, 3);
    run_op(1'b0, PAT, 4'd3, res, lat);
    checks += 2;
    if (lat !== 5) begin errors++; $display("FAIL bp_latency got %0d want 5", lat); end
    if (res !== exp_r) begin errors++; $display("FAIL bp_cout got %h want %h", res, exp_r); end
    for (int i = 0; i < 5; i++) begin
      in_valid   = (i % 2 == 0);
      c          = {10{$urandom}};
      num_rounds = 4'(i);
      @(negedge clk);
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_ov[%0d] got %b want 1", i, out_valid); end
      if (cout !== exp_r) begin errors++; $display("FAIL bp_hold_cout[%0d] got %h want %h", i, cout, exp_r); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
    end
    in_valid = 1'b0;
    consume(1'b0);
    repeat (3) @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %b want 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL bp_ignored_busy got %b want 0", busy); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle got %b want 1", in_ready); end
  endtask

  task automatic test_mid_reset;
    logic [CW-1:0] res;
    int lat;
    bit seen;
    @(negedge clk);
    in_valid = 1'b1; c = PAT; num_rounds = 4'd12;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks += 1;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
    #2 reset = 1'b1;
    #1;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_ov got %b want 0", out_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got %b want 0", in_ready); end
    if (cout !== '0) begin errors++; $display("FAIL mid_rst_cout got %h want 0", cout); end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks += 1;
    if (seen !== 1'b0) begin errors++; $display("FAIL mid_stale_output got %b want 0", seen); end
    run_op(1'b0, ~PAT, 4'd12, res, lat);
    checks += 2;
    if (lat !== 14) begin errors++; $display("FAIL mid_fresh_latency got %0d want 14", lat); end
    if (res !== model(~PAT, 12)) begin errors++; $display("FAIL mid_fresh_cout got %h want %h", res, model(~PAT, 12)); end
    consume(1'b0);
  endtask

  task automatic test_random;
    logic [CW-1:0] cv, res, exp_r;
    logic [3:0]    nr;
    int            lat, n, exp_lat, hold;
    bit            u3;
    for (int it = 0; it < 1000; it++) begin
      u3 = it[0];
      cv = {$urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom, $urandom};
      nr = 4'($urandom_range(0, 15));
      n  = (int'(nr) > 12) ? 12 : int'(nr);
      exp_lat = 2 + (u3 ? (n + 2) / 3 : n);
      exp_r = model(cv, int'(nr));
      run_op(u3, cv, nr, res, lat);
      checks += 2;
      if (lat !== exp_lat) begin errors++; $display("FAIL rnd_latency[%0d] got %0d want %0d", it, lat, exp_lat); end
      if (res !== exp_r) begin errors++; $display("FAIL rnd_cout[%0d] got %h want %h", it, res, exp_r); end
      hold = $urandom_range(0, 3);
      repeat (hold) @(negedge clk);
      checks += 1;
      if ((u3 ? cout3 : cout) !== exp_r) begin
        errors++;
        $display("FAIL rnd_stable[%0d] got %h want %h", it, u3 ? cout3 : cout, exp_r);
      end
      consume(u3);
      checks += 1;
      if ((u3 ? out_valid3 : out_valid) !== 1'b0) begin
        errors++;
        $display("FAIL rnd_consumed[%0d] got 1 want 0", it);
      end
    end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; c = '0; num_rounds = '0;
    in_valid3 = 1'b0; out_ready3 = 1'b0; c3 = '0; num_rounds3 = '0;
    test_reset();
    test_full_rounds();
    test_passthrough_clamp();
    test_unroll();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
